// File: rtl/alu_pkg.sv
// Shared opcode encoding, FSM states and the per-opcode register update mask
// for the ALU issue/commit block.
package alu_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned OP_W   = 4;

    typedef enum logic [OP_W-1:0] {
        NOP = 4'b0000,
        ADD = 4'b0001,
        SUB = 4'b0010,
        MUL = 4'b0011,
        DIV = 4'b0100,
        DA  = 4'b0101,
        NOT = 4'b0110,
        AND = 4'b0111,
        XOR = 4'b1000,
        OR  = 4'b1001
    } op_code_t;

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_t;

    // Which architectural fields an opcode writes on commit, and from where.
    typedef struct packed {
        logic acc_we;
        logic acc_from_des1;
        logic b_we;
        logic cy_we;
        logic cy_clr;
        logic ac_we;
        logic ov_we;
        logic ov_clr;
    } upd_mask_t;

    function automatic upd_mask_t upd_mask(input logic [OP_W-1:0] op);
        upd_mask_t m;
        m = '0;
        case (op)
            ADD, SUB: begin
                m.acc_we = 1'b1;
                m.cy_we  = 1'b1;
                m.ac_we  = 1'b1;
                m.ov_we  = 1'b1;
            end
            DA, NOT, AND, XOR, OR: begin
                m.acc_we = 1'b1;
                m.cy_we  = 1'b1;
            end
            MUL: begin
                m.acc_we        = 1'b1;
                m.acc_from_des1 = 1'b1;
                m.b_we          = 1'b1;
                m.cy_we         = 1'b1;
                m.cy_clr        = 1'b1;
                m.ov_we         = 1'b1;
            end
            DIV: begin
                m.acc_we        = 1'b1;
                m.acc_from_des1 = 1'b1;
                m.b_we          = 1'b1;
                m.cy_we         = 1'b1;
                m.cy_clr        = 1'b1;
                m.ov_we         = 1'b1;
                m.ov_clr        = 1'b1;
            end
            default: m = '0;
        endcase
        return m;
    endfunction

    function automatic logic is_illegal(input logic [OP_W-1:0] op);
        return op > OR;
    endfunction

endpackage

// File: rtl/alu_issue_commit_if.sv
// Decoder issue handshake plus the ALU drive/result bus seen by alu_issue_commit.
interface alu_issue_commit_if;

    logic                         issue_valid;
    logic                         issue_ready;
    logic [alu_pkg::OP_W-1:0]     issue_op;
    logic [alu_pkg::DATA_W-1:0]   issue_src2;
    logic                         issue_bit;
    logic                         abort;

    logic [alu_pkg::OP_W-1:0]     alu_op_code;
    logic [alu_pkg::DATA_W-1:0]   alu_src1;
    logic [alu_pkg::DATA_W-1:0]   alu_src2;
    logic                         alu_bit_in;
    logic                         alu_src_cy;
    logic                         alu_src_ac;

    logic [alu_pkg::DATA_W-1:0]   des_acc;
    logic [alu_pkg::DATA_W-1:0]   des1;
    logic [alu_pkg::DATA_W-1:0]   des2;
    logic                         desCy;
    logic                         desAc;
    logic                         desOv;

    // Environment side: decoder plus ALU.
    modport master (
        output issue_valid, issue_op, issue_src2, issue_bit, abort,
        output des_acc, des1, des2, desCy, desAc, desOv,
        input  issue_ready,
        input  alu_op_code, alu_src1, alu_src2, alu_bit_in, alu_src_cy, alu_src_ac
    );

    modport slave (
        input  issue_valid, issue_op, issue_src2, issue_bit, abort,
        input  des_acc, des1, des2, desCy, desAc, desOv,
        output issue_ready,
        output alu_op_code, alu_src1, alu_src2, alu_bit_in, alu_src_cy, alu_src_ac
    );

endinterface

// File: rtl/alu_commit_regs.sv
// Architectural ACC/B/PSW registers: selects and applies ALU results on a
// commit strobe; parity always tracks the accumulator.
module alu_commit_regs
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              commit,
    input  logic [OP_W-1:0]   op,
    input  logic              src2_zero,
    input  logic [DATA_W-1:0] des_acc,
    input  logic [DATA_W-1:0] des1,
    input  logic [DATA_W-1:0] des2,
    input  logic              des_cy,
    input  logic              des_ac,
    input  logic              des_ov,
    output logic [DATA_W-1:0] acc,
    output logic [DATA_W-1:0] b_reg,
    output logic              psw_cy,
    output logic              psw_ac,
    output logic              psw_ov,
    output logic              psw_p
);

    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic              cy_q, cy_d;
    logic              ac_q, ac_d;
    logic              ov_q, ov_d;
    logic              p_q, p_d;
    upd_mask_t         m;
    logic              div_zero;

    always_comb begin
        m        = upd_mask(op);
        div_zero = (op == DIV) && src2_zero;
        acc_d    = acc_q;
        b_d      = b_q;
        cy_d     = cy_q;
        ac_d     = ac_q;
        ov_d     = ov_q;
        if (commit) begin
            // Divide by zero keeps ACC/B and only reports overflow.
            if (m.acc_we && !div_zero) acc_d = m.acc_from_des1 ? des1 : des_acc;
            if (m.b_we && !div_zero)   b_d   = des2;
            if (m.cy_we)               cy_d  = m.cy_clr ? 1'b0 : des_cy;
            if (m.ac_we)               ac_d  = des_ac;
            if (m.ov_we)               ov_d  = div_zero ? 1'b1 : (m.ov_clr ? 1'b0 : des_ov);
        end
        p_d = ^acc_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q <= '0;
            b_q   <= '0;
            cy_q  <= 1'b0;
            ac_q  <= 1'b0;
            ov_q  <= 1'b0;
            p_q   <= 1'b0;
        end else begin
            acc_q <= acc_d;
            b_q   <= b_d;
            cy_q  <= cy_d;
            ac_q  <= ac_d;
            ov_q  <= ov_d;
            p_q   <= p_d;
        end
    end

    assign acc    = acc_q;
    assign b_reg  = b_q;
    assign psw_cy = cy_q;
    assign psw_ac = ac_q;
    assign psw_ov = ov_q;
    assign psw_p  = p_q;

endmodule

// File: rtl/alu_issue_commit.sv
// Issues one decoded op to the ALU, waits its latency (1, MUL_LAT or DIV_LAT)
// and commits the results into ACC/B/PSW; abort cancels an in-flight op.
module alu_issue_commit
    import alu_pkg::*;
#(
    parameter int unsigned MUL_LAT = 4,
    parameter int unsigned DIV_LAT = 8
) (
    input  logic              clk,
    input  logic              rst,
    alu_issue_commit_if.slave bus,
    output logic [DATA_W-1:0] acc,
    output logic [DATA_W-1:0] b_reg,
    output logic              psw_cy,
    output logic              psw_ac,
    output logic              psw_ov,
    output logic              psw_p,
    output logic              wr_done,
    output logic              illegal
);

    localparam int unsigned MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int unsigned CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic [DATA_W-1:0] src2_q, src2_d;
    logic              bit_q, bit_d;
    logic              wr_done_q, wr_done_d;
    logic              illegal_q, illegal_d;
    logic              commit_c;

    // Remaining edges after the accept edge before the commit edge.
    function automatic logic [CNT_W-1:0] lat_m1(input logic [OP_W-1:0] op);
        logic [CNT_W-1:0] n;
        case (op)
            MUL:     n = CNT_W'(MUL_LAT - 1);
            DIV:     n = CNT_W'(DIV_LAT - 1);
            default: n = '0;
        endcase
        return n;
    endfunction

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        src2_d    = src2_q;
        bit_d     = bit_q;
        wr_done_d = 1'b0;
        illegal_d = 1'b0;
        commit_c  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.issue_valid) begin
                    state_d = EXEC;
                    op_d    = bus.issue_op;
                    src2_d  = bus.issue_src2;
                    bit_d   = bus.issue_bit;
                    cnt_d   = lat_m1(bus.issue_op);
                end
            end
            EXEC: begin
                // Abort takes priority over a commit on the same edge.
                if (bus.abort) begin
                    state_d = IDLE;
                    op_d    = NOP;
                end else if (cnt_q == '0) begin
                    commit_c  = 1'b1;
                    wr_done_d = 1'b1;
                    illegal_d = is_illegal(op_q);
                    state_d   = IDLE;
                    op_d      = NOP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                op_d    = NOP;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            op_q      <= NOP;
            src2_q    <= '0;
            bit_q     <= 1'b0;
            wr_done_q <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            src2_q    <= src2_d;
            bit_q     <= bit_d;
            wr_done_q <= wr_done_d;
            illegal_q <= illegal_d;
        end
    end

    alu_commit_regs u_regs (
        .clk       (clk),
        .rst       (rst),
        .commit    (commit_c),
        .op        (op_q),
        .src2_zero (src2_q == '0),
        .des_acc   (bus.des_acc),
        .des1      (bus.des1),
        .des2      (bus.des2),
        .des_cy    (bus.desCy),
        .des_ac    (bus.desAc),
        .des_ov    (bus.desOv),
        .acc       (acc),
        .b_reg     (b_reg),
        .psw_cy    (psw_cy),
        .psw_ac    (psw_ac),
        .psw_ov    (psw_ov),
        .psw_p     (psw_p)
    );

    assign bus.issue_ready = (state_q == IDLE);
    assign bus.alu_op_code = op_q;
    assign bus.alu_src1    = acc;
    assign bus.alu_src2    = src2_q;
    assign bus.alu_bit_in  = bit_q;
    assign bus.alu_src_cy  = psw_cy;
    assign bus.alu_src_ac  = psw_ac;
    assign wr_done         = wr_done_q;
    assign illegal         = illegal_q;

endmodule

// File: tb/tb_alu_issue_commit.sv
// Scoreboard bench for alu_issue_commit: a behavioural ALU drives des_*, a
// reference model predicts architectural state per issued op.
module tb_alu_issue_commit;
    import alu_pkg::*;

    localparam int MUL_L = 4;
    localparam int DIV_L = 8;

    typedef struct packed {
        logic [7:0] acc; logic [7:0] d1; logic [7:0] d2;
        logic cy; logic ac; logic ov;
    } alu_out_t;
    typedef struct packed {
        logic [7:0] acc; logic [7:0] b; logic cy; logic ac; logic ov;
    } arch_t;
    typedef struct {
        arch_t st; logic ill; int cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] acc, b_reg;
    logic       psw_cy, psw_ac, psw_ov, psw_p, wr_done, illegal;
    alu_out_t   alu_o;
    exp_t       exp_q[$];
    arch_t      model;
    int         cyc = 0;
    int         n_pass = 0;
    int         n_checks = 0;
    logic       prev_wr = 1'b0;

    alu_issue_commit_if bus ();

    alu_issue_commit #(.MUL_LAT(MUL_L), .DIV_LAT(DIV_L)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .acc(acc), .b_reg(b_reg), .psw_cy(psw_cy), .psw_ac(psw_ac),
        .psw_ov(psw_ov), .psw_p(psw_p), .wr_done(wr_done), .illegal(illegal)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Plain-arithmetic ALU; fields an opcode does not define get junk values.
    function automatic alu_out_t alu_eval(input logic [3:0] op, input logic [7:0] a,
                                          input logic [7:0] s, input logic bt,
                                          input logic cy, input logic ac);
        alu_out_t r;
        int t, sv;
        r.acc = a ^ s; r.d1 = ~a; r.d2 = s + 8'd1;
        r.cy = ~cy; r.ac = a[0] ^ s[3]; r.ov = ^s;
        case (op)
            4'd1: begin
                t = int'(a) + int'(s);
                sv = int'($signed(a)) + int'($signed(s));
                r.acc = 8'(t); r.cy = t > 255;
                r.ac = (int'(a[3:0]) + int'(s[3:0])) > 15;
                r.ov = (sv > 127) || (sv < -128);
            end
            4'd2: begin
                t = int'(a) - int'(s) - int'(cy);
                sv = int'($signed(a)) - int'($signed(s)) - int'(cy);
                r.acc = 8'(t); r.cy = t < 0;
                r.ac = (int'(a[3:0]) - int'(s[3:0]) - int'(cy)) < 0;
                r.ov = (sv > 127) || (sv < -128);
            end
            4'd3: begin
                t = int'(a) * int'(s);
                r.d1 = 8'(t); r.d2 = 8'(t / 256); r.ov = t > 255;
            end
            4'd4: begin
                if (s != 8'd0) begin
                    r.d1 = 8'(int'(a) / int'(s)); r.d2 = 8'(int'(a) % int'(s)); r.ov = 1'b0;
                end else begin
                    r.d1 = 8'hEE; r.d2 = 8'hDD; r.ov = 1'b1;
                end
            end
            4'd5: begin
                t = int'(a);
                if (int'(a[3:0]) > 9 || ac) t = t + 6;
                if (t > 159 || cy) t = t + 96;
                r.acc = 8'(t); r.cy = cy || (t > 255);
            end
            4'd6: begin r.acc = ~a;    r.cy = ~cy;     end
            4'd7: begin r.acc = a & s; r.cy = cy & bt; end
            4'd8: begin r.acc = a ^ s; r.cy = cy ^ bt; end
            4'd9: begin r.acc = a | s; r.cy = cy | bt; end
            default: ;
        endcase
        return r;
    endfunction

    always_comb alu_o = alu_eval(bus.alu_op_code, bus.alu_src1, bus.alu_src2,
                                 bus.alu_bit_in, bus.alu_src_cy, bus.alu_src_ac);
    assign bus.des_acc = alu_o.acc;
    assign bus.des1    = alu_o.d1;
    assign bus.des2    = alu_o.d2;
    assign bus.desCy   = alu_o.cy;
    assign bus.desAc   = alu_o.ac;
    assign bus.desOv   = alu_o.ov;

    // Architectural effect of one completed op.
    function automatic arch_t ref_apply(input arch_t s, input logic [3:0] op,
                                        input logic [7:0] s2, input logic bt);
        arch_t r;
        alu_out_t o;
        r = s;
        o = alu_eval(op, s.acc, s2, bt, s.cy, s.ac);
        if (op == 4'd1 || op == 4'd2) begin
            r.acc = o.acc; r.cy = o.cy; r.ac = o.ac; r.ov = o.ov;
        end else if (op >= 4'd5 && op <= 4'd9) begin
            r.acc = o.acc; r.cy = o.cy;
        end else if (op == 4'd3) begin
            r.acc = o.d1; r.b = o.d2; r.cy = 1'b0; r.ov = o.ov;
        end else if (op == 4'd4) begin
            r.cy = 1'b0;
            if (s2 == 8'd0) r.ov = 1'b1;
            else begin r.acc = o.d1; r.b = o.d2; r.ov = 1'b0; end
        end
        return r;
    endfunction

    function automatic int lat_of(input logic [3:0] op);
        return (op == 4'd3) ? MUL_L : (op == 4'd4) ? DIV_L : 1;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        n_checks++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, want);
    endtask

    task automatic chk_arch(input string name, input logic [7:0] a, input logic [7:0] b,
                            input logic cy, input logic ov);
        check(name, 64'({acc, b_reg, psw_cy, psw_ov}), 64'({a, b, cy, ov}));
    endtask

    // Monitor: every wr_done pops one prediction.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            if (wr_done) begin
                check("wr_done_single_pulse", 64'(prev_wr), 64'd0);
                if (exp_q.size() == 0) begin
                    check("unexpected_wr_done", 64'(wr_done), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("commit_cycle", 64'(cyc), 64'(e.cyc));
                    check("commit_state",
                          64'({acc, b_reg, psw_cy, psw_ac, psw_ov, psw_p, illegal}),
                          64'({e.st.acc, e.st.b, e.st.cy, e.st.ac, e.st.ov,
                               1'($countones(e.st.acc) % 2), e.ill}));
                end
            end else if (illegal) begin
                check("illegal_without_wr_done", 64'(illegal), 64'd0);
            end
            prev_wr <= wr_done;
        end else begin
            prev_wr <= 1'b0;
        end
    end

    // abort_at: -1 none, 0 asserted on the accept edge (IDLE), k>0 on edge T0+k.
    task automatic run_op(input logic [3:0] op, input logic [7:0] s2, input logic bt,
                          input int abort_at, input bit hold);
        int lat, j;
        bit aborted;
        exp_t e;
        lat = lat_of(op);
        aborted = (abort_at >= 1) && (abort_at <= lat);
        @(negedge clk);
        j = 0;
        while (!bus.issue_ready && j < 40) begin @(negedge clk); j++; end
        if (!bus.issue_ready) begin
            check("ready_timeout", 64'(bus.issue_ready), 64'd1);
            return;
        end
        if (!aborted) begin
            e.st = ref_apply(model, op, s2, bt);
            e.ill = op > 4'd9;
            e.cyc = cyc + 1 + lat;
            exp_q.push_back(e);
            model = e.st;
        end
        bus.issue_valid = 1'b1; bus.issue_op = op; bus.issue_src2 = s2; bus.issue_bit = bt;
        bus.abort = (abort_at == 0);
        @(posedge clk); #1;
        bus.abort = 1'b0;
        if (!hold) bus.issue_valid = 1'b0;
        check("ready_low_after_accept", 64'(bus.issue_ready), 64'd0);
        check("op_code_in_exec", 64'(bus.alu_op_code), 64'(op));
        j = 0;
        while (j < 40) begin
            @(negedge clk);
            bus.abort = 1'b0;
            if (bus.issue_ready) break;
            j++;
            if (j == abort_at) bus.abort = 1'b1;
        end
        bus.issue_valid = 1'b0;
        check("busy_cycles", 64'(j), 64'(aborted ? abort_at : lat));
        check("op_code_idle", 64'(bus.alu_op_code), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [3:0] op;
        int ab;
        bus.issue_valid = 1'b0; bus.issue_op = 4'd0; bus.issue_src2 = 8'd0;
        bus.issue_bit = 1'b0; bus.abort = 1'b0;
        model = '0;
        #2 rst = 1'b0;
        #1;
        check("reset_state", 64'({acc, b_reg, psw_cy, psw_ac, psw_ov, psw_p, wr_done, illegal}), 64'd0);
        check("reset_ready_opcode", 64'({bus.issue_ready, bus.alu_op_code}), 64'h10);
        @(negedge clk) rst = 1'b1;

        run_op(4'd1, 8'h3A, 1'b0, -1, 1'b0);
        run_op(4'd1, 8'h48, 1'b0, -1, 1'b0);
        chk_arch("add_result", 8'h82, 8'h00, 1'b0, 1'b1);
        check("add_ac_p", 64'({psw_ac, psw_p}), 64'b10);

        run_op(4'd7, 8'h00, 1'b0, -1, 1'b0);
        run_op(4'd9, 8'h50, 1'b0, -1, 1'b0);
        run_op(4'd3, 8'hA0, 1'b0, -1, 1'b1);
        chk_arch("mul_result", 8'h00, 8'h32, 1'b0, 1'b1);

        run_op(4'd9, 8'h22, 1'b0, -1, 1'b0);
        run_op(4'd3, 8'h80, 1'b0, -1, 1'b0);
        run_op(4'd9, 8'h7F, 1'b0, -1, 1'b0);
        run_op(4'd4, 8'h00, 1'b0, -1, 1'b0);
        chk_arch("div_by_zero", 8'h7F, 8'h11, 1'b0, 1'b1);

        run_op(4'd9, 8'hFF, 1'b0, -1, 1'b0);
        run_op(4'd4, 8'h10, 1'b0, 3, 1'b0);
        chk_arch("div_abort_mid", 8'hFF, 8'h11, 1'b0, 1'b1);
        run_op(4'd4, 8'h10, 1'b0, DIV_L, 1'b0);
        chk_arch("div_abort_commit_edge", 8'hFF, 8'h11, 1'b0, 1'b1);
        run_op(4'd4, 8'h10, 1'b0, 0, 1'b0);
        chk_arch("div_idle_abort_ignored", 8'h0F, 8'h0F, 1'b0, 1'b0);

        run_op(4'hC, 8'h55, 1'b1, -1, 1'b0);
        chk_arch("illegal_no_change", 8'h0F, 8'h0F, 1'b0, 1'b0);

        // Asynchronous reset in the middle of a MUL.
        @(negedge clk);
        bus.issue_valid = 1'b1; bus.issue_op = 4'd3; bus.issue_src2 = 8'h05;
        @(posedge clk); #1 bus.issue_valid = 1'b0;
        @(posedge clk); @(posedge clk); #2;
        rst = 1'b0;
        #1;
        check("async_reset_regs", 64'({acc, b_reg, psw_cy, psw_ac, psw_ov, psw_p, wr_done, illegal}), 64'd0);
        check("async_reset_ready_opcode", 64'({bus.issue_ready, bus.alu_op_code}), 64'h10);
        @(negedge clk) rst = 1'b1;
        model = '0;
        run_op(4'd1, 8'h3A, 1'b0, -1, 1'b0);
        chk_arch("add_after_reset", 8'h3A, 8'h00, 1'b0, 1'b0);

        for (int i = 0; i < 300; i++) begin
            op = 4'($urandom_range(0, 15));
            ab = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, lat_of(op))) : -1;
            run_op(op, ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom),
                   1'($urandom), ab, ($urandom_range(0, 3) == 0));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (4) @(negedge clk);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_issue_commit.md
Name: alu_issue_commit

Overview:
Driver/consumer on the far side of the 8-bit ALU datapath. Accepts one operation from the decoder and drives the ALU op_code, operands and carry-in flags. Waits the op's latency (single-cycle, or multi-cycle MUL/DIV) and commits ALU results into the architectural ACC, B and PSW flags (CY, AC, OV, P). Sits between the instruction decoder and the ALU.

Parameters:
MUL_LAT, 4, cycles from accept edge to commit edge for MUL (>=1)
DIV_LAT, 8, cycles from accept edge to commit edge for DIV (>=1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
issue_valid  in  1  decoder presents an op
issue_ready  out  1  high only in IDLE
issue_op  in  4  opcode (package encoding)
issue_src2  in  8  second operand
issue_bit  in  1  bit operand for logic/carry ops
abort  in  1  cancel in-flight op
alu_op_code  out  4  to ALU op_code
alu_src1  out  8  to ALU src1; equals acc
alu_src2  out  8  latched issue_src2
alu_bit_in  out  1  latched issue_bit
alu_src_cy  out  1  equals psw_cy
alu_src_ac  out  1  equals psw_ac
des_acc, des1, des2  in  8 each  ALU results
desCy, desAc, desOv  in  1 each  ALU flag results
acc  out  8  accumulator
b_reg  out  8  B register
psw_cy, psw_ac, psw_ov, psw_p  out  1 each  flags
wr_done  out  1  one-cycle pulse after each commit
illegal  out  1  one-cycle pulse for an unknown opcode

Behaviour:
- Reset (rst=0, async) clears acc, b_reg and all flags to 0, wr_done and illegal to 0, and alu_op_code to NOP (0000). State returns to IDLE immediately, including mid-operation.
- States: IDLE, EXEC.
- IDLE: issue_ready=1 and alu_op_code=NOP. On issue_valid at edge T0, latch op/src2/bit and load cnt = L-1 (L=1 single-cycle, MUL_LAT, DIV_LAT). Go to EXEC.
- EXEC: issue_ready=0, alu_op_code=latched op, and issue_valid is ignored.
  - At each edge with cnt!=0, decrement cnt.
  - At the edge with cnt==0, commit, pulse wr_done next cycle, and return to IDLE.
  - Commit edge = T0+L. Minimum spacing between accepts = L+1 cycles.
- abort high in EXEC: return to IDLE at that edge with no register or flag change and no wr_done. Abort on the commit edge wins over commit. abort in IDLE is ignored.
- Commit rules:
  - ADD(0001), SUB(0010): acc<=des_acc; cy,ac,ov <= desCy,desAc,desOv.
  - DA(0101): acc<=des_acc; cy<=desCy.
  - NOT(0110), AND(0111), XOR(1000), OR(1001): acc<=des_acc; cy<=desCy; ac,ov unchanged.
  - MUL(0011): acc<=des1 (low), b_reg<=des2 (high); cy<=0; ov<=desOv.
  - DIV(0100): acc<=des1 (quotient), b_reg<=des2 (remainder); cy<=0; ov<=0.
  - DIV with latched src2==0: acc,b_reg unchanged; ov<=1; cy<=0.
  - NOP(0000): accepted with L=1; no change; wr_done still pulses.
  - 1010-1111: accepted with L=1; no change; wr_done and illegal pulse together.
- psw_p = XOR-reduction of acc (odd parity count -> 1); always consistent with acc.
- b_reg changes only on MUL/DIV.
- Counter width = $clog2(max(MUL_LAT,DIV_LAT)).

Decomposition:
- Package alu_pkg: op_code_t enum with the 4-bit encodings above; constants NOP/ADD/SUB/MUL/DIV/DA/NOT/AND/XOR/OR; flag-update-mask function per opcode.
- One sub-module: alu_commit_regs, holding ACC/B/PSW registers, the commit mux and parity. The top holds the FSM and counter.

Test Plan:
- ADD: acc=0x3A, src2=0x48, flags 0 -> one cycle after accept edge: acc=0x82, cy=0, ac=1, ov=1, p=0; wr_done single pulse; issue_ready low for exactly one cycle.
- MUL: acc=0x50, src2=0xA0 -> commit at T0+4: acc=0x00, b_reg=0x32, cy=0, ov=1; issue_valid held high during EXEC not re-accepted.
- DIV by zero: acc=0x7F, b_reg=0x11, src2=0x00 -> commit at T0+8: acc=0x7F, b_reg=0x11, ov=1, cy=0.
- DIV 0xFF/0x10 with abort at T0+3 -> acc/b/flags unchanged, no wr_done, issue_ready high at T0+4; abort coincident with commit edge also suppresses commit.
- issue_op=1100 -> wr_done and illegal pulse together one cycle after accept; all registers unchanged.
- Async reset asserted mid-MUL (T0+2) -> acc/b/flags=0 and alu_op_code=0000 without a clock edge; after release, next ADD completes normally.
